tape_line_in: RTL and testbench
===============================

Name: tape_line_in

Overview:
- Conditions the raw analog-comparator tape line input (TAPE_SOUND pin) before it reaches the console's svi_tap_i.
- Synchronises the pin to clk_sys, rejects glitches, and produces a clean tape bit.
- Also produces an edge strobe, the last half-period length, and a carrier-detect flag used for the LED and for selecting audio.
- Sits upstream of cv_console, in parallel with the CAS file cassette reader; the top level muxes the two by status[15].

Parameters:
FILTER_LEN, 8, consecutive differing synchronised samples required before tap_o changes (min 1)
CARRIER_TIMEOUT, 1000000, cycles without an edge before carrier is dropped (about 23 ms at 42.66 MHz)
MIN_EDGES, 16, edges required inside the timeout window before carrier_o asserts (min 1)

Ports:
clk_i  in  1  system clock (clk_sys)
reset_n_i  in  1  asynchronous active-low reset
en_i  in  1  line-input mode enable; low clears all internal state synchronously
line_i  in  1  raw asynchronous tape line input
tap_o  out  1  filtered tape bit to console svi_tap_i
edge_o  out  1  one-cycle pulse on every tap_o transition
period_o  out  16  cycles between the last two tap_o transitions, saturating
carrier_o  out  1  tape signal present
led_o  out  1  tap_o AND carrier_o

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n_i); clock is clk_i.
- Reset values: all outputs 0, all counters 0, sync flops 0.
- Sync: 2-flop synchroniser; s2 is the synchronised sample.
- Glitch filter, counter fcnt:
  - s2==tap_o: fcnt<=0.
  - s2!=tap_o and fcnt==FILTER_LEN-1: tap_o<=s2, fcnt<=0.
  - Otherwise fcnt<=fcnt+1.
  - Latency from a stable pin change to tap_o change: FILTER_LEN+2 cycles. Pulses shorter than FILTER_LEN samples are never propagated.
- edge_o: high for exactly the cycle after tap_o changes (registered from the toggle condition, aligned with the new tap_o value).
- Period counter pcnt, 16-bit:
  - Increments each cycle, saturating at 16'hFFFF.
  - On toggle: period_o<=sat(pcnt+1), pcnt<=0.
  - period_o holds between toggles; a saturated value stays FFFF.
- Carrier detect, timeout counter tcnt and edge counter ecnt:
  - On toggle: tcnt<=0, ecnt<=min(ecnt+1, MIN_EDGES). When the new ecnt equals MIN_EDGES, carrier_o<=1 in the same update.
  - No toggle: tcnt increments. When tcnt reaches CARRIER_TIMEOUT-1: carrier_o<=0, ecnt<=0, tcnt<=0.
  - Toggle and timeout in the same cycle: the toggle wins (tcnt<=0, ecnt counts).
- en_i low: fcnt, pcnt, tcnt, ecnt, tap_o, edge_o, period_o and carrier_o all cleared on the next edge; sync flops keep running. Re-enabling starts from the cleared state.
- Asynchronous reset mid-operation: immediate clear; no pending edge is emitted after release.
- led_o is combinational AND of the registered tap_o and carrier_o.

Optional Feature:
- Macro TAPE_LINE_IN_INVERT_EN.
- Defined: the synchroniser samples ~line_i, for inverting line buffers. Reset value of tap_o stays 0; the first filtered change drives tap_o to 1 when the pin is low.
- Not defined: line_i sampled as-is.
- All timing is identical in both builds.

Test Plan:
- FILTER_LEN=8: line_i rises and stays high -> tap_o=1 exactly 10 cycles later; edge_o pulses one cycle; period_o equals the cycle count from reset.
- 7-cycle high glitch on a low line -> tap_o stays 0, no edge_o, fcnt back to 0.
- Square wave with a 100-cycle half-period, MIN_EDGES=16 -> period_o=100 after the second edge; carrier_o rises on the 16th edge; led_o follows tap_o after that.
- Stop toggling with CARRIER_TIMEOUT=1000 -> carrier_o falls 1000 cycles after the last edge. An edge landing on cycle 1000 instead keeps carrier_o=1.
- Hold the line static for 70000 cycles, then toggle -> period_o=FFFF.
- en_i low mid-stream, then high, and separately reset_n_i pulse mid-stream -> all outputs 0 immediately after; carrier needs 16 fresh edges to reassert.

Source files
------------

// File: rtl/tape_line_in.sv
// tape_line_in: conditions the raw tape comparator input for the console tape port.
// Synchronises the pin, glitch-filters it, and derives an edge strobe,
// the last half-period length and a carrier-detect flag.
// Optional build macro: TAPE_LINE_IN_INVERT_EN samples the inverted pin
// for inverting line buffers. Timing is identical in both builds.
module tape_line_in #(
  parameter int unsigned FILTER_LEN      = 8,
  parameter int unsigned CARRIER_TIMEOUT = 1000000,
  parameter int unsigned MIN_EDGES       = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        en_i,
  input  logic        line_i,
  output logic        tap_o,
  output logic        edge_o,
  output logic [15:0] period_o,
  output logic        carrier_o,
  output logic        led_o
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (CARRIER_TIMEOUT > 1) ? $clog2(CARRIER_TIMEOUT) : 1;
  localparam int unsigned EW = $clog2(MIN_EDGES + 1);
  localparam int unsigned PW = 16;

  logic          line_s;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          tap_q, tap_d;
  logic          edge_q, edge_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic          carrier_q, carrier_d;

  logic          toggle;
  logic [PW-1:0] pcnt_inc;
  logic [EW-1:0] ecnt_inc;

`ifdef TAPE_LINE_IN_INVERT_EN
  assign line_s = ~line_i;
`else
  assign line_s = line_i;
`endif

  // Synchroniser keeps running regardless of enable
  always_comb begin
    s1_d = line_s;
    s2_d = s1_q;
  end

  // Glitch filter, period measurement and carrier detect
  always_comb begin
    fcnt_d    = fcnt_q;
    tap_d     = tap_q;
    edge_d    = 1'b0;
    pcnt_d    = pcnt_q;
    period_d  = period_q;
    tcnt_d    = tcnt_q;
    ecnt_d    = ecnt_q;
    carrier_d = carrier_q;
    toggle    = 1'b0;
    pcnt_inc  = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
    ecnt_inc  = (ecnt_q == EW'(MIN_EDGES)) ? ecnt_q : ecnt_q + EW'(1);

    if (!en_i) begin
      fcnt_d    = '0;
      tap_d     = 1'b0;
      pcnt_d    = '0;
      period_d  = '0;
      tcnt_d    = '0;
      ecnt_d    = '0;
      carrier_d = 1'b0;
    end else begin
      if (s2_q == tap_q) begin
        fcnt_d = '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        tap_d  = s2_q;
        fcnt_d = '0;
        toggle = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end

      edge_d = toggle;

      if (toggle) begin
        period_d = pcnt_inc;
        pcnt_d   = '0;
      end else begin
        pcnt_d   = pcnt_inc;
      end

      // An edge always beats a simultaneous timeout
      if (toggle) begin
        tcnt_d = '0;
        ecnt_d = ecnt_inc;
        if (ecnt_inc == EW'(MIN_EDGES)) begin
          carrier_d = 1'b1;
        end
      end else if (tcnt_q == TW'(CARRIER_TIMEOUT - 1)) begin
        tcnt_d    = '0;
        ecnt_d    = '0;
        carrier_d = 1'b0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      fcnt_q    <= '0;
      tap_q     <= 1'b0;
      edge_q    <= 1'b0;
      pcnt_q    <= '0;
      period_q  <= '0;
      tcnt_q    <= '0;
      ecnt_q    <= '0;
      carrier_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      fcnt_q    <= fcnt_d;
      tap_q     <= tap_d;
      edge_q    <= edge_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      tcnt_q    <= tcnt_d;
      ecnt_q    <= ecnt_d;
      carrier_q <= carrier_d;
    end
  end

  assign tap_o     = tap_q;
  assign edge_o    = edge_q;
  assign period_o  = period_q;
  assign carrier_o = carrier_q;
  assign led_o     = tap_q & carrier_q;

endmodule

// File: tb/tb_tape_line_in.sv
// Directed testbench for tape_line_in (FILTER_LEN=8, CARRIER_TIMEOUT=1000, MIN_EDGES=16).
module tb_tape_line_in;

  localparam int unsigned FL = 8;
  localparam int unsigned CT = 1000;
  localparam int unsigned ME = 16;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        line;
  logic        tap;
  logic        edge_s;
  logic [15:0] period;
  logic        carrier;
  logic        led;

  int checks = 0;
  int errors = 0;

  tape_line_in #(
    .FILTER_LEN(FL),
    .CARRIER_TIMEOUT(CT),
    .MIN_EDGES(ME)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .en_i(en),
    .line_i(line),
    .tap_o(tap),
    .edge_o(edge_s),
    .period_o(period),
    .carrier_o(carrier),
    .led_o(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (tap !== 1'b0 || edge_s !== 1'b0 || period !== 16'd0 || carrier !== 1'b0 || led !== 1'b0) begin
      errors++;
      $display("FAIL %s: tap=%b edge=%b period=%h carrier=%b led=%b, required all 0",
               name, tap, edge_s, period, carrier, led);
    end
  endtask

  // Square wave with 100-cycle half-period; carrier expected from the ME-th edge on,
  // assuming the edge counter starts cleared
  task automatic square(input int n, input string name);
    for (int i = 1; i <= n; i++) begin
      line = ~line;
      tick(9);
      checks++;
      if (tap !== ~line) begin
        errors++;
        $display("FAIL %s_early edge %0d: tap=%b required %b", name, i, tap, ~line);
      end
      tick(1);
      checks++;
      if (tap !== line || edge_s !== 1'b1) begin
        errors++;
        $display("FAIL %s_edge %0d: tap=%b edge=%b required tap=%b edge=1", name, i, tap, edge_s, line);
      end
      if (i >= 2) begin
        checks++;
        if (period !== 16'd100) begin
          errors++;
          $display("FAIL %s_period edge %0d: got %0d required 100", name, i, period);
        end
      end
      checks++;
      if (carrier !== (i >= int'(ME)) || led !== ((i >= int'(ME)) && line)) begin
        errors++;
        $display("FAIL %s_carrier edge %0d: carrier=%b led=%b required carrier=%b led=%b",
                 name, i, carrier, led, (i >= int'(ME)), ((i >= int'(ME)) && line));
      end
      tick(1);
      checks++;
      if (edge_s !== 1'b0) begin
        errors++;
        $display("FAIL %s_edge_width edge %0d: edge=%b required 0", name, i, edge_s);
      end
      tick(89);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    line    = 1'b0;
    #2;
    check_all_zero("reset");
    tick(3);
    check_all_zero("reset_held");
  endtask

  task automatic test_rise();
    reset_n = 1'b1;
    line    = 1'b1;
    tick(9);
    checks++;
    if (tap !== 1'b0 || period !== 16'd0) begin
      errors++;
      $display("FAIL rise_early: tap=%b period=%0d required tap=0 period=0", tap, period);
    end
    tick(1);
    checks++;
    if (tap !== 1'b1 || edge_s !== 1'b1 || period !== 16'd10 || carrier !== 1'b0 || led !== 1'b0) begin
      errors++;
      $display("FAIL rise: tap=%b edge=%b period=%0d carrier=%b led=%b required 1 1 10 0 0",
               tap, edge_s, period, carrier, led);
    end
    tick(1);
    checks++;
    if (edge_s !== 1'b0 || tap !== 1'b1 || period !== 16'd10) begin
      errors++;
      $display("FAIL rise_after: edge=%b tap=%b period=%0d required 0 1 10", edge_s, tap, period);
    end
  endtask

  task automatic test_glitch();
    int edges_seen;
    logic tap_seen;
    line = 1'b0;
    tick(20);
    checks++;
    if (tap !== 1'b0) begin
      errors++;
      $display("FAIL glitch_setup: tap=%b required 0", tap);
    end
    // 7-cycle pulse is rejected
    tap_seen = 1'b0;
    edges_seen = 0;
    for (int j = 0; j < 30; j++) begin
      if (j == 0) line = 1'b1;
      if (j == int'(FL) - 1) line = 1'b0;
      tick(1);
      if (tap) tap_seen = 1'b1;
      if (edge_s) edges_seen++;
    end
    checks++;
    if (tap_seen !== 1'b0 || edges_seen != 0) begin
      errors++;
      $display("FAIL glitch_short: tap_seen=%b edges=%0d required 0 0", tap_seen, edges_seen);
    end
    checks++;
    if (dut.fcnt_q !== 3'd0) begin
      errors++;
      $display("FAIL glitch_fcnt: fcnt=%0d required 0", dut.fcnt_q);
    end
    // 8-cycle pulse passes through as a single clean pulse
    tap_seen = 1'b0;
    edges_seen = 0;
    for (int j = 0; j < 30; j++) begin
      if (j == 0) line = 1'b1;
      if (j == int'(FL)) line = 1'b0;
      tick(1);
      if (tap) tap_seen = 1'b1;
      if (edge_s) edges_seen++;
    end
    checks++;
    if (tap_seen !== 1'b1 || edges_seen != 2 || tap !== 1'b0) begin
      errors++;
      $display("FAIL glitch_min: tap_seen=%b edges=%0d tap=%b required 1 2 0", tap_seen, edges_seen, tap);
    end
    tick(1100);
    checks++;
    if (carrier !== 1'b0) begin
      errors++;
      $display("FAIL glitch_carrier: carrier=%b required 0", carrier);
    end
  endtask

  task automatic test_timeout();
    // Now 90 cycles past the last tap edge
    tick(909);
    checks++;
    if (carrier !== 1'b1) begin
      errors++;
      $display("FAIL timeout_999: carrier=%b required 1", carrier);
    end
    tick(1);
    checks++;
    if (carrier !== 1'b0 || led !== 1'b0) begin
      errors++;
      $display("FAIL timeout_1000: carrier=%b led=%b required 0 0", carrier, led);
    end
    // Rebuild carrier, then land an edge exactly on the timeout cycle
    square(16, "resq");
    tick(900);
    line = ~line;
    tick(10);
    checks++;
    if (carrier !== 1'b1 || edge_s !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge_wins: carrier=%b edge=%b required 1 1", carrier, edge_s);
    end
    tick(1);
    checks++;
    if (carrier !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge_hold: carrier=%b required 1", carrier);
    end
  endtask

  task automatic test_period_sat();
    tick(70000);
    line = ~line;
    tick(10);
    checks++;
    if (edge_s !== 1'b1 || period !== 16'hFFFF) begin
      errors++;
      $display("FAIL period_sat: edge=%b period=%h required 1 FFFF", edge_s, period);
    end
    tick(90);
    line = ~line;
    tick(10);
    checks++;
    if (edge_s !== 1'b1 || period !== 16'd100) begin
      errors++;
      $display("FAIL period_unsat: edge=%b period=%0d required 1 100", edge_s, period);
    end
    tick(1100);
  endtask

  task automatic test_enable();
    square(16, "ensq");
    line = 1'b1;
    tick(20);
    checks++;
    if (tap !== 1'b1 || carrier !== 1'b1 || led !== 1'b1) begin
      errors++;
      $display("FAIL en_before: tap=%b carrier=%b led=%b required 1 1 1", tap, carrier, led);
    end
    en = 1'b0;
    tick(1);
    check_all_zero("en_low");
    line = 1'b0;
    tick(5);
    en = 1'b1;
    tick(30);
    check_all_zero("en_reenable");
    square(16, "en_fresh");
  endtask

  task automatic test_async_reset();
    line = 1'b1;
    tick(20);
    checks++;
    if (tap !== 1'b1 || carrier !== 1'b1) begin
      errors++;
      $display("FAIL rst_before: tap=%b carrier=%b required 1 1", tap, carrier);
    end
    line = 1'b0;
    tick(5);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_immediate");
    tick(2);
    reset_n = 1'b1;
    tick(30);
    check_all_zero("rst_release");
    square(16, "rst_fresh");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    square(20, "sq");
    test_timeout();
    test_period_sat();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
